button_reader: RTL
==================

BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_MAX, default 250000, meaning the number of consecutive clkin cycles a synchronized input must be stable before it is accepted (10 ms at 25 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_BITS, default 18, meaning the debounce counter width, which is at least ceil(log2(DEBOUNCE_MAX+1)).
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 12500000, meaning the hold cycles before the first auto-repeat (used only with BUTTON_READER_REPEAT_EN).
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 2500000, meaning the cycles between subsequent auto-repeats (used only with BUTTON_READER_REPEAT_EN).
REQ-005 The block SHALL have port clkin, input, 1 bit: the 25 MHz board clock and the only clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port sw, input, [0:3]: raw asynchronous push-button levels, 1 = pressed.
REQ-008 The block SHALL have port level, output, [0:3]: the debounced button state.
REQ-009 The block SHALL have port pressed, output, [0:3]: one-cycle press-event pulses per button.
REQ-010 The block SHALL have port press_count, output, [0:3]: the running count of press events, which can be wired directly to the LEDs.

Function
REQ-011 Each sw bit SHALL pass through a 2-flop synchronizer, and only the synchronized value SHALL be used downstream.
REQ-012 Each button SHALL have an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a DEBOUNCE_BITS counter.
REQ-013 In RELEASED, when sync=1 the FSM SHALL go to PRESS_WAIT with counter=0; otherwise it SHALL stay in RELEASED.
REQ-014 In PRESS_WAIT, sync=0 SHALL return the FSM to RELEASED with no event, and sync=1 SHALL increment the counter.
REQ-015 In PRESS_WAIT, when the counter reaches DEBOUNCE_MAX-1 with sync=1, the FSM SHALL go to PRESSED, set level=1 and assert pressed for exactly one cycle.
REQ-016 PRESSED and RELEASE_WAIT SHALL mirror REQ-013 to REQ-015 with the polarity inverted; the RELEASE_WAIT timeout SHALL clear level and SHALL NOT generate a pulse.
REQ-017 Latency from the first clkin edge sampling sw=1 to the pressed pulse SHALL be 2+DEBOUNCE_MAX cycles; level SHALL rise in the same cycle as the pulse.
REQ-018 Any glitch shorter than DEBOUNCE_MAX synchronized cycles SHALL produce no change on level, pressed or press_count.
REQ-019 In the cycle after the pressed pulses, press_count SHALL increase by the popcount of pressed, modulo 16.
REQ-020 A press_count wrap from 15 SHALL go to 0 (or 1 to 3 when several buttons fire together).
REQ-021 Simultaneous events on several buttons SHALL all be counted in the same cycle, and none SHALL be dropped.

Reset
REQ-022 While rst=1 at a clkin edge, all FSMs SHALL enter RELEASED, and counters, synchronizers, level, pressed and press_count SHALL clear to 0.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the pending event.
REQ-024 After reset, a button held through the reset release SHALL be accepted as a new press 2+DEBOUNCE_MAX cycles after rst falls.

Configuration
REQ-025 With BUTTON_READER_REPEAT_EN defined, a button staying in PRESSED SHALL emit a further pressed pulse after REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles until it leaves PRESSED, and each repeat SHALL be counted as in REQ-019.
REQ-026 The repeat timer SHALL restart at each new entry into PRESSED.
REQ-027 Without BUTTON_READER_REPEAT_EN defined, the block SHALL emit exactly one pulse per accepted press, and no repeat logic SHALL be synthesized.

Verification (DEBOUNCE_MAX=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-028 Scenario "clean press": sw[0] 0->1 held 20 cycles -> pressed[0] high exactly one cycle, 6 cycles after the first sampled 1; level[0]=1; press_count=1.
REQ-029 Scenario "bounce": sw[1] toggling every 2 cycles for 30 cycles, then 0 -> no pulse, level[1]=0 throughout, press_count unchanged.
REQ-030 Scenario "simultaneous": sw[0:3]=1111 applied together -> pressed=1111 for one cycle; press_count advances by 4, and starting from 14 it becomes 2.
REQ-031 Scenario "reset mid-debounce": sw[2]=1, then rst pulsed 1 cycle at debounce count 2 -> all outputs 0; pulse arrives 6 cycles after rst falls.
REQ-032 Scenario "repeat": with BUTTON_READER_REPEAT_EN, sw[3] held 60 cycles -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; without the macro, one pulse only.

Source files
------------

// File: rtl/button_reader.sv
// button_reader: four push-button front end. Each button is synchronized,
// debounced by its own four-state FSM and turned into a level plus a
// one-cycle press pulse; accepted presses are counted modulo 16.
// Optional auto-repeat while a button is held: define BUTTON_READER_REPEAT_EN.
module button_reader #(
    parameter int DEBOUNCE_MAX  = 250000,
    parameter int DEBOUNCE_BITS = 18,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [0:3] sw,
    output logic [0:3] level,
    output logic [0:3] pressed,
    output logic [0:3] press_count
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam logic [DEBOUNCE_BITS-1:0] DB_ZERO   = {DEBOUNCE_BITS{1'b0}};
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE    = DEBOUNCE_BITS'(1);
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX_M1 = DEBOUNCE_BITS'(DEBOUNCE_MAX - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_MAX < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        DEBOUNCE_BITS < $clog2(DEBOUNCE_MAX + 1)) begin : g_bad_cfg
        $error("button_reader: invalid parameter set");
    end

`ifdef BUTTON_READER_REPEAT_EN
    localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_BITS = $clog2(RPT_MAX + 1);
    localparam logic [RPT_BITS-1:0] RPT_ZERO   = {RPT_BITS{1'b0}};
    localparam logic [RPT_BITS-1:0] RPT_ONE    = RPT_BITS'(1);
    localparam logic [RPT_BITS-1:0] RPT_DLY_M1 = RPT_BITS'(REPEAT_DELAY - 1);
    localparam logic [RPT_BITS-1:0] RPT_PER_M1 = RPT_BITS'(REPEAT_PERIOD - 1);
`endif

    // Number of set bits in a 4-bit event vector (0..4).
    function automatic logic [2:0] popcount4(input logic [0:3] v);
        logic [2:0] acc;
        acc = 3'd0;
        for (int k = 0; k < 4; k++) begin
            acc = acc + {2'b00, v[k]};
        end
        return acc;
    endfunction

    logic [0:3]               sync1_q;
    logic [0:3]               sync2_q;
    btn_state_e               state_q   [0:3];
    btn_state_e               state_d   [0:3];
    logic [DEBOUNCE_BITS-1:0] cnt_q     [0:3];
    logic [DEBOUNCE_BITS-1:0] cnt_d     [0:3];
    logic [0:3]               level_q;
    logic [0:3]               level_d;
    logic [0:3]               pressed_q;
    logic [0:3]               pressed_d;
    logic [3:0]               press_count_q;
    logic [3:0]               press_count_d;
`ifdef BUTTON_READER_REPEAT_EN
    logic [RPT_BITS-1:0]      rpt_cnt_q   [0:3];
    logic [RPT_BITS-1:0]      rpt_cnt_d   [0:3];
    logic [0:3]               rpt_first_q;
    logic [0:3]               rpt_first_d;
`endif

    // Per-button debounce FSM next-state, level and pulse computation.
    always_comb begin
        level_d   = level_q;
        pressed_d = 4'b0000;
`ifdef BUTTON_READER_REPEAT_EN
        rpt_first_d = rpt_first_q;
`endif
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef BUTTON_READER_REPEAT_EN
            rpt_cnt_d[i] = rpt_cnt_q[i];
`endif
            case (state_q[i])
                RELEASED: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = DB_ZERO;
                    end else begin
                        state_d[i] = RELEASED;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = DB_ZERO;
                    end else if (cnt_q[i] == DB_MAX_M1) begin
                        state_d[i]   = PRESSED;
                        cnt_d[i]     = DB_ZERO;
                        level_d[i]   = 1'b1;
                        pressed_d[i] = 1'b1;
`ifdef BUTTON_READER_REPEAT_EN
                        rpt_cnt_d[i]   = RPT_ZERO;
                        rpt_first_d[i] = 1'b1;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = DB_ZERO;
                    end else begin
                        state_d[i] = PRESSED;
`ifdef BUTTON_READER_REPEAT_EN
                        // First repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
                        if (rpt_cnt_q[i] == (rpt_first_q[i] ? RPT_DLY_M1 : RPT_PER_M1)) begin
                            pressed_d[i]   = 1'b1;
                            rpt_cnt_d[i]   = RPT_ZERO;
                            rpt_first_d[i] = 1'b0;
                        end else begin
                            rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_ONE;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // A release bounce returns to PRESSED; the repeat timer is
                    // frozen meanwhile rather than restarted.
                    if (sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = DB_ZERO;
                    end else if (cnt_q[i] == DB_MAX_M1) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = DB_ZERO;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + DB_ONE;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = DB_ZERO;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    // Count last cycle's pulses; several simultaneous events add together.
    always_comb begin
        press_count_d = press_count_q + {1'b0, popcount4(pressed_q)};
    end

    // Synchronizers, FSM state, counters and registered outputs.
    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1_q       <= 4'b0000;
            sync2_q       <= 4'b0000;
            level_q       <= 4'b0000;
            pressed_q     <= 4'b0000;
            press_count_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= DB_ZERO;
            end
`ifdef BUTTON_READER_REPEAT_EN
            rpt_first_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                rpt_cnt_q[i] <= RPT_ZERO;
            end
`endif
        end else begin
            sync1_q       <= sw;
            sync2_q       <= sync1_q;
            level_q       <= level_d;
            pressed_q     <= pressed_d;
            press_count_q <= press_count_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
`ifdef BUTTON_READER_REPEAT_EN
            rpt_first_q <= rpt_first_d;
            for (int i = 0; i < 4; i++) begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
`endif
        end
    end

    assign level       = level_q;
    assign pressed     = pressed_q;
    assign press_count = press_count_q;

endmodule
